// File: rtl/icm_lookup_rr_arbiter_if.sv
// Lookup request/response handshake bundle shared by the channels and the engine.
// A master issues lookups and accepts responses; a slave serves them.
`ifndef ICM_SPACE_ADDR_WIDTH
`define ICM_SPACE_ADDR_WIDTH 64
`endif
`ifndef PHY_SPACE_ADDR_WIDTH
`define PHY_SPACE_ADDR_WIDTH 64
`endif

interface icm_lookup_rr_arbiter_if #(
  parameter int HEAD_WIDTH     = 14,
  parameter int ICM_ADDR_WIDTH = `ICM_SPACE_ADDR_WIDTH,
  parameter int PHY_ADDR_WIDTH = `PHY_SPACE_ADDR_WIDTH
);
  logic                      lookup_valid;
  logic [HEAD_WIDTH-1:0]     lookup_head;
  logic                      lookup_ready;
  logic                      rsp_valid;
  logic [ICM_ADDR_WIDTH-1:0] rsp_icm_addr;
  logic [PHY_ADDR_WIDTH-1:0] rsp_phy_addr;
  logic                      rsp_ready;

  modport master (
    output lookup_valid,
    output lookup_head,
    output rsp_ready,
    input  lookup_ready,
    input  rsp_valid,
    input  rsp_icm_addr,
    input  rsp_phy_addr
  );

  modport slave (
    input  lookup_valid,
    input  lookup_head,
    input  rsp_ready,
    output lookup_ready,
    output rsp_valid,
    output rsp_icm_addr,
    output rsp_phy_addr
  );
endinterface

// File: rtl/icm_lookup_rr_arbiter.sv
// Two-channel round-robin arbiter in front of an in-order ICM lookup engine.
// A tag FIFO of channel ids routes each engine response back to its requester.
`ifndef ICM_SPACE_ADDR_WIDTH
`define ICM_SPACE_ADDR_WIDTH 64
`endif
`ifndef PHY_SPACE_ADDR_WIDTH
`define PHY_SPACE_ADDR_WIDTH 64
`endif

module icm_lookup_rr_arbiter #(
  parameter int HEAD_WIDTH     = 14,
  parameter int ICM_ADDR_WIDTH = `ICM_SPACE_ADDR_WIDTH,
  parameter int PHY_ADDR_WIDTH = `PHY_SPACE_ADDR_WIDTH,
  parameter int TAG_DEPTH      = 8,
  parameter int TAG_DEPTH_LOG  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  icm_lookup_rr_arbiter_if.slave   chnl_0,
  icm_lookup_rr_arbiter_if.slave   chnl_1,
  icm_lookup_rr_arbiter_if.master  eng,
  output logic [TAG_DEPTH_LOG:0]   outstanding_cnt,
  output logic                     err_orphan_rsp
);

  localparam logic [TAG_DEPTH_LOG:0] FULL_CNT =
    (TAG_DEPTH_LOG+1)'(TAG_DEPTH);

  logic [TAG_DEPTH-1:0]     tags;
  logic [TAG_DEPTH_LOG-1:0] wr_ptr;
  logic [TAG_DEPTH_LOG-1:0] rd_ptr;
  logic [TAG_DEPTH_LOG:0]   cnt;

  logic last_grant;
  logic locked;
  logic lock_ch;
  logic lock_hit;
  logic gnt;
  logic lv;
  logic full;
  logic empty;
  logic issue;
  logic head_ch;
  logic rr;
  logic pop;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

  // A stalled request keeps its channel until the engine takes it
  assign lock_hit = locked &&
    (lock_ch ? chnl_1.lookup_valid : chnl_0.lookup_valid);

  always_comb begin
    gnt = 1'b0;
    if (lock_hit)
      gnt = lock_ch;
    else if (chnl_0.lookup_valid && chnl_1.lookup_valid)
      gnt = ~last_grant;
    else if (chnl_1.lookup_valid)
      gnt = 1'b1;
  end

  assign lv = rst && !full &&
    (chnl_0.lookup_valid || chnl_1.lookup_valid);

  assign issue = lv && eng.lookup_ready;

  assign eng.lookup_valid = lv;
  assign eng.lookup_head  = !lv ? '0 :
    (gnt ? chnl_1.lookup_head : chnl_0.lookup_head);

  assign chnl_0.lookup_ready = lv && !gnt && eng.lookup_ready;
  assign chnl_1.lookup_ready = lv &&  gnt && eng.lookup_ready;

  assign head_ch = tags[rd_ptr];
  assign rr      = !empty &&
    (head_ch ? chnl_1.rsp_ready : chnl_0.rsp_ready);
  assign pop     = eng.rsp_valid && rr;

  assign eng.rsp_ready = rr;

  assign chnl_0.rsp_valid    = eng.rsp_valid && !empty && !head_ch;
  assign chnl_1.rsp_valid    = eng.rsp_valid && !empty &&  head_ch;
  assign chnl_0.rsp_icm_addr = eng.rsp_icm_addr;
  assign chnl_1.rsp_icm_addr = eng.rsp_icm_addr;
  assign chnl_0.rsp_phy_addr = eng.rsp_phy_addr;
  assign chnl_1.rsp_phy_addr = eng.rsp_phy_addr;

  assign outstanding_cnt = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tags   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (issue) begin
        tags[wr_ptr] <= gnt;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (issue && !pop)
        cnt <= cnt + 1'b1;
      else if (!issue && pop)
        cnt <= cnt - 1'b1;
    end
  end

  // last_grant resets to 1 so channel 0 wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant     <= 1'b1;
      locked         <= 1'b0;
      lock_ch        <= 1'b0;
      err_orphan_rsp <= 1'b0;
    end else begin
      if (issue) begin
        last_grant <= gnt;
        locked     <= 1'b0;
      end else if (lv) begin
        locked  <= 1'b1;
        lock_ch <= gnt;
      end
      if (eng.rsp_valid && empty)
        err_orphan_rsp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icm_lookup_rr_arbiter.sv
// Random-stimulus bench for icm_lookup_rr_arbiter.
// Compares every cycle against a queue-based model of the arbiter.
module tb_icm_lookup_rr_arbiter;

  localparam int HW = 14;
  localparam int IW = 64;
  localparam int PW = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  icm_lookup_rr_arbiter_if #(HW, IW, PW) c0 ();
  icm_lookup_rr_arbiter_if #(HW, IW, PW) c1 ();
  icm_lookup_rr_arbiter_if #(HW, IW, PW) eng ();

  logic [3:0] cnt;
  logic       err;

  icm_lookup_rr_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .chnl_0          (c0),
    .chnl_1          (c1),
    .eng             (eng),
    .outstanding_cnt (cnt),
    .err_orphan_rsp  (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state: queue of channel ids awaiting a response
  int q[$];
  int last;
  bit lk;
  int lk_ch;
  bit err_m;

  bit          v[2];
  logic [HW-1:0] h[2];
  bit          crr[2];
  bit          lr;
  bit          rv;
  logic [63:0] ia;
  logic [63:0] pa;

  task automatic cycle(input bit in_rst, input int req_pct,
                       input int lr_pct, input int rv_pct);
    bit full, empty, elv, both;
    int g, k;
    logic [HW-1:0] ehead;
    bit erdy0, erdy1, erv0, erv1, err_r;
    @(negedge clk);
    rst = !in_rst;
    for (int n = 0; n < 2; n++) begin
      if (!v[n] && $urandom_range(99) < req_pct) begin
        v[n] = 1'b1;
        h[n] = HW'($urandom);
      end
      crr[n] = $urandom_range(99) < 70;
    end
    lr = $urandom_range(99) < lr_pct;
    rv = $urandom_range(99) < rv_pct;
    ia = {$urandom, $urandom};
    pa = {$urandom, $urandom};
    c0.lookup_valid = v[0];
    c0.lookup_head  = h[0];
    c0.rsp_ready    = crr[0];
    c1.lookup_valid = v[1];
    c1.lookup_head  = h[1];
    c1.rsp_ready    = crr[1];
    eng.lookup_ready = lr;
    eng.rsp_valid    = rv;
    eng.rsp_icm_addr = ia;
    eng.rsp_phy_addr = pa;
    #1;
    if (in_rst) begin
      q.delete();
      last  = 1;
      lk    = 1'b0;
      err_m = 1'b0;
      chk("rst_lookup_valid", eng.lookup_valid, 0);
      chk("rst_rsp_ready", eng.rsp_ready, 0);
      chk("rst_rdy0", c0.lookup_ready, 0);
      chk("rst_rdy1", c1.lookup_ready, 0);
      chk("rst_rv0", c0.rsp_valid, 0);
      chk("rst_rv1", c1.rsp_valid, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_err", err, 0);
      return;
    end
    full  = (q.size() == 8);
    empty = (q.size() == 0);
    both  = v[0] && v[1];
    elv   = (v[0] || v[1]) && !full;
    if (lk && v[lk_ch]) g = lk_ch;
    else if (both)      g = 1 - last;
    else                g = v[1] ? 1 : 0;
    ehead = elv ? h[g] : '0;
    erdy0 = elv && lr && (g == 0);
    erdy1 = elv && lr && (g == 1);
    k     = empty ? 0 : q[0];
    erv0  = rv && !empty && (k == 0);
    erv1  = rv && !empty && (k == 1);
    err_r = !empty && crr[k];
    chk("lookup_valid", eng.lookup_valid, elv);
    chk("lookup_head", eng.lookup_head, ehead);
    chk("lookup_ready0", c0.lookup_ready, erdy0);
    chk("lookup_ready1", c1.lookup_ready, erdy1);
    chk("rsp_valid0", c0.rsp_valid, erv0);
    chk("rsp_valid1", c1.rsp_valid, erv1);
    chk("rsp_ready", eng.rsp_ready, err_r);
    chk("cnt", cnt, q.size());
    chk("err_orphan", err, err_m);
    chk("icm0", c0.rsp_icm_addr, ia);
    chk("phy1", c1.rsp_phy_addr, pa);
    if (rv && err_r) void'(q.pop_front());
    if (elv && lr) begin
      q.push_back(g);
      last = g;
      lk   = 1'b0;
      v[g] = 1'b0;
    end else if (elv) begin
      lk    = 1'b1;
      lk_ch = g;
    end
    if (rv && empty) err_m = 1'b1;
  endtask

  initial begin
    v = '{0, 0};
    h = '{0, 0};
    repeat (3) cycle(1, 50, 50, 50);
    repeat (40)  cycle(0, 100, 100, 0);
    repeat (30)  cycle(0, 80, 30, 0);
    repeat (60)  cycle(0, 90, 90, 60);
    repeat (4)   cycle(1, 90, 90, 50);
    repeat (200) cycle(0, 60, 70, 50);
    repeat (60)  cycle(0, 90, 90, 5);
    repeat (3)   cycle(1, 40, 40, 40);
    repeat (300) cycle(0, 50, 50, 45);
    repeat (150) cycle(0, 95, 60, 70);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
